state_seq_ctrl: RTL and testbench

- Sequences a bank of NUM_WORDS enable-gated word registers (the state store) that sits in front of a permutation/round core.
- Loads the bank word-by-word from a narrow valid/ready input stream, then starts the core and waits for it to finish.
- Captures the core result into the bank in one cycle, then streams the bank out word-by-word over a valid/ready output.
- The block drives only enables, selects and handshakes. Word data and registers live outside it.

---
 rtl/state_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_state_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_seq_ctrl.sv
// state_seq_ctrl
//   Sequencer for a bank of NUM_WORDS enable-gated word registers that feeds a
//   permutation/round core. It loads the bank one word per input handshake,
//   pulses core_start, waits for core_done, captures the core result into all
//   words at once, then streams the bank out one word per output handshake.
//   Only enables, selects and handshakes are produced here; the word
//   registers and the core live outside this block.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   in_data/in_valid      input word stream; in_ready is high only in LOAD
//   wr_en                 per-word register enable (bit i -> word i)
//   wr_data               data for the bank when src_sel=0 (== in_data)
//   src_sel               0: bank loads wr_data, 1: bank loads core result
//   core_start/core_done  one-cycle start pulse / result-valid from the core
//   rd_sel                output mux index into the bank
//   out_valid/out_ready   output word stream (bank[rd_sel])
//   busy                  low only when idle in LOAD with no word accepted
module state_seq_ctrl #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_WORDS-1:0] wr_en,
  output logic [WORD_W-1:0]    wr_data,
  output logic                 src_sel,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [CNT_W-1:0]     rd_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_e           fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= LOAD;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_data = in_data;
  assign busy    = !((fsm_q == LOAD) && (cnt_q == '0));

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    wr_en      = '0;
    src_sel    = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    rd_sel     = '0;

    case (fsm_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = NUM_WORDS'(1) << cnt_q;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            fsm_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      START: begin
        core_start = 1'b1;
        fsm_d      = WAIT;
      end

      WAIT: begin
        // src_sel stays high for the whole wait so the bank input mux is
        // already settled on the core result when core_done arrives.
        src_sel = 1'b1;
        if (core_done) begin
          wr_en = '1;
          cnt_d = '0;
          fsm_d = UNLOAD;
        end
      end

      UNLOAD: begin
        out_valid = 1'b1;
        rd_sel    = cnt_q;
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            fsm_d = LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        cnt_d = '0;
        fsm_d = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_state_seq_ctrl.sv
// tb_state_seq_ctrl
//   Scoreboard bench for state_seq_ctrl. The stimulus process walks a
//   transaction-level model (words accepted so far, wait length, words sent)
//   and pushes each expected event (bank write mask, core start, output
//   handshake index) with the cycle it must occur in. A monitor samples the
//   DUT on the falling edge, pops events as the DUT produces them, and also
//   compares per-cycle handshake levels published by the stimulus process.
module tb_state_seq_ctrl;

  localparam int NW = 4;
  localparam int WW = 32;
  localparam int CW = 2;

  localparam int EV_WR    = 0;
  localparam int EV_START = 1;
  localparam int EV_OUT   = 2;

  logic          clk;
  logic          rst;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] wr_en;
  logic [WW-1:0] wr_data;
  logic          src_sel;
  logic          core_start;
  logic          core_done;
  logic [CW-1:0] rd_sel;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  state_seq_ctrl #(
    .WORD_W   (WW),
    .NUM_WORDS(NW),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .src_sel   (src_sel),
    .core_start(core_start),
    .core_done (core_done),
    .rd_sel    (rd_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    int          kind;
    int unsigned val;
    int unsigned cyc;
  } ev_t;

  ev_t         evq[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  bit          mon_en;

  // Expected handshake levels for the current cycle.
  bit          e_in_ready;
  bit          e_src_sel;
  bit          e_busy;
  bit          e_out_valid;
  int unsigned e_rd_sel;

  // Per-transaction stall plan.
  int unsigned g_in_st[NW];
  int unsigned g_out_st[NW];
  int unsigned g_wlen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic pop_ev(input int kind, input int unsigned val, input string name);
    ev_t e;
    if (evq.size() == 0) begin
      n_checks++;
      $display("FAIL %s at cycle %0d: unexpected event value 0x%0h, expected none", name, cyc, val);
    end else begin
      e = evq.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_val"}, val, e.val);
      chk({name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      chk("in_ready", in_ready, e_in_ready);
      chk("src_sel", src_sel, e_src_sel);
      chk("busy", busy, e_busy);
      chk("out_valid", out_valid, e_out_valid);
      chk("wr_data", wr_data, in_data);
      if (e_out_valid) chk("rd_sel", rd_sel, e_rd_sel);
      if (wr_en != '0) pop_ev(EV_WR, wr_en, "wr_en");
      if (core_start) pop_ev(EV_START, 1, "core_start");
      if (out_valid && out_ready) pop_ev(EV_OUT, rd_sel, "out_hs");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int unsigned val, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    evq.push_back(e);
  endtask

  task automatic set_exp(input bit ir, input bit ss, input bit bz, input bit ov, input int unsigned rs);
    e_in_ready  = ir;
    e_src_sel   = ss;
    e_busy      = bz;
    e_out_valid = ov;
    e_rd_sel    = rs;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    core_done = 1'b0;
    out_ready = 1'b0;
    set_exp(1, 0, 0, 0, 0);
  endtask

  // Loads `nwords` words following g_in_st; spurious core_done/out_ready.
  task automatic load_words(input int unsigned nwords);
    for (int unsigned i = 0; i < nwords; i++) begin
      for (int unsigned s = 0; s < g_in_st[i]; s++) begin
        in_valid  = 1'b0;
        core_done = 1'($urandom);
        out_ready = 1'($urandom);
        in_data   = $urandom;
        set_exp(1, 0, i != 0, 0, 0);
        tick();
      end
      in_valid  = 1'b1;
      core_done = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = 32'hA0 + i;
      set_exp(1, 0, i != 0, 0, 0);
      push(EV_WR, 1 << i, cyc);
      tick();
    end
  endtask

  // One full load / core / unload transaction; entered and left in idle LOAD.
  task automatic run_txn();
    int unsigned t_last;
    load_words(NW);
    t_last = cyc - 1;
    // START: in_valid and core_done must both be ignored.
    in_valid  = 1'($urandom);
    core_done = 1'($urandom);
    out_ready = 1'($urandom);
    set_exp(0, 0, 1, 0, 0);
    push(EV_START, 1, t_last + 1);
    tick();
    for (int unsigned w = 0; w < g_wlen; w++) begin
      in_valid  = 1'($urandom);
      core_done = 1'b0;
      out_ready = 1'($urandom);
      set_exp(0, 1, 1, 0, 0);
      tick();
    end
    in_valid  = 1'($urandom);
    core_done = 1'b1;
    set_exp(0, 1, 1, 0, 0);
    push(EV_WR, (1 << NW) - 1, t_last + 2 + g_wlen);
    tick();
    for (int unsigned k = 0; k < NW; k++) begin
      for (int unsigned s = 0; s < g_out_st[k]; s++) begin
        in_valid  = 1'($urandom);
        core_done = 1'($urandom);
        out_ready = 1'b0;
        set_exp(0, 0, 1, 1, k);
        tick();
      end
      in_valid  = 1'($urandom);
      core_done = 1'($urandom);
      out_ready = 1'b1;
      set_exp(0, 0, 1, 1, k);
      push(EV_OUT, k, cyc);
      tick();
    end
    idle();
  endtask

  task automatic random_plan();
    for (int unsigned i = 0; i < NW; i++) begin
      g_in_st[i]  = $urandom_range(0, 3);
      g_out_st[i] = $urandom_range(0, 3);
    end
    g_wlen = $urandom_range(0, 12);
  endtask

  task automatic check_reset_levels(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_src_sel"}, src_sel, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_rd_sel"}, rd_sel, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    mon_en    = 1'b0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    core_done = 1'b0;
    out_ready = 1'b0;
    idle();
    #2;
    check_reset_levels("por");
    tick();
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();

    // Directed: in_valid 1,0,0,1,1,1; 10-cycle wait; out_ready 0,1,0,0,1,1,1.
    g_in_st  = '{0, 2, 0, 0};
    g_wlen   = 10;
    g_out_st = '{1, 2, 0, 0};
    run_txn();

    // Back-to-back with no stalls at all.
    g_in_st  = '{0, 0, 0, 0};
    g_wlen   = 0;
    g_out_st = '{0, 0, 0, 0};
    run_txn();

    // Reset in the middle of a load: two words in, then async reset.
    load_words(2);
    in_valid  = 1'b0;
    core_done = 1'b0;
    out_ready = 1'b0;
    set_exp(1, 0, 1, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    check_reset_levels("midload_rst");
    tick();
    rst = 1'b1;
    idle();
    tick();
    // After abandoning the partial load the first accept targets word 0.
    g_in_st = '{1, 0, 0, 0};
    g_wlen  = 3;
    g_out_st = '{0, 1, 0, 0};
    run_txn();

    for (int t = 0; t < 8; t++) begin
      random_plan();
      run_txn();
    end

    tick();
    tick();
    chk("events_outstanding", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound on simulated time in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d events outstanding", evq.size());
    $fatal(1, "timeout");
  end

endmodule
